// File: rtl/uart_pkg.sv
// Shared UART definitions: baud rate codes, the rate table in Hz and the
// clock-to-divisor helper used to elaborate divisor tables.
package uart_pkg;

    localparam logic [3:0] BAUD_300    = 4'd0;
    localparam logic [3:0] BAUD_1200   = 4'd1;
    localparam logic [3:0] BAUD_2400   = 4'd2;
    localparam logic [3:0] BAUD_4800   = 4'd3;
    localparam logic [3:0] BAUD_9600   = 4'd4;
    localparam logic [3:0] BAUD_19200  = 4'd5;
    localparam logic [3:0] BAUD_38400  = 4'd6;
    localparam logic [3:0] BAUD_57600  = 4'd7;
    localparam logic [3:0] BAUD_115200 = 4'd8;
    localparam logic [3:0] BAUD_230400 = 4'd9;
    localparam logic [3:0] BAUD_460800 = 4'd10;
    localparam logic [3:0] BAUD_921600 = 4'd11;
    localparam logic [3:0] BAUD_CUSTOM = 4'd15;

    localparam int unsigned RATE_HZ [12] = '{
        300, 1200, 2400, 4800, 9600, 19200,
        38400, 57600, 115200, 230400, 460800, 921600
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PEND
    } brg_state_t;

    // Codes without a table entry fall back to 300 baud.
    function automatic int unsigned rate_of(input logic [3:0] code);
        if (code < 4'd12) begin
            return RATE_HZ[code];
        end
        return RATE_HZ[0];
    endfunction

    // Rounded clock-periods-per-symbol.
    function automatic int unsigned div_of(input int unsigned clk_hz,
                                           input int unsigned rate);
        return (clk_hz + rate / 2) / rate;
    endfunction

endpackage

// File: rtl/baud_div_table.sv
// Combinational rate-code to bit-period resolve. Custom divisor support
// (code 15, clamped to 2*OVERSAMPLE) is compiled only with BAUD_CUSTOM_EN.
module baud_div_table
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int          OVERSAMPLE = 16,
    parameter int          CNT_W      = 20
) (
    input  logic [3:0]       code,
    input  logic [CNT_W-1:0] custom_div,
    output logic [CNT_W-1:0] div
);

    logic [CNT_W-1:0] tab [16];

    // Divisors are fixed at elaboration, so no divider is built.
    for (genvar g = 0; g < 16; g++) begin : g_tab
        localparam int unsigned D = div_of(CLK_HZ, rate_of(4'(g)));
        assign tab[g] = CNT_W'(D);
    end

`ifdef BAUD_CUSTOM_EN
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2 * OVERSAMPLE);

    always_comb begin
        div = tab[code];
        if (code == BAUD_CUSTOM) begin
            div = (custom_div < DIV_MIN) ? DIV_MIN : custom_div;
        end
    end
`else
    logic unused_custom;
    assign unused_custom = ^custom_div;

    always_comb begin
        div = tab[code];
    end
`endif

endmodule

// File: rtl/baud_rate_gen.sv
// UART baud-rate generator: bit and oversample ticks, glitch-free rate change
// at bit boundaries, mid-bit realignment. Optional macro: BAUD_CUSTOM_EN.
module baud_rate_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int          OVERSAMPLE = 16,
    parameter int          CNT_W      = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       baud,
    input  logic             baud_we,
    input  logic [CNT_W-1:0] custom_div,
    input  logic             sync_clear,
    output logic             bit_tick,
    output logic             os_tick,
    output logic [CNT_W-1:0] div_out,
    output logic             pending,
    output logic             rate_ack
);

    localparam int               OS_SH   = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] DIV_300 = CNT_W'(div_of(CLK_HZ, RATE_HZ[0]));

    brg_state_t       st_q, st_d;
    logic [CNT_W-1:0] res_div;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] os_div;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] os_cnt;
    logic             sync_act;
    logic             wrap_bit;
    logic             wrap_os;
    logic             apply;

    baud_div_table #(
        .CLK_HZ     (CLK_HZ),
        .OVERSAMPLE (OVERSAMPLE),
        .CNT_W      (CNT_W)
    ) u_table (
        .code       (baud),
        .custom_div (custom_div),
        .div        (res_div)
    );

    // Floor division; the remainder is absorbed by the restart at bit_tick.
    assign os_div   = div_q >> OS_SH;
    assign sync_act = enable & sync_clear;
    assign wrap_bit = enable && (bit_cnt == div_q - 1'b1);
    assign wrap_os  = enable && (os_cnt == os_div - 1'b1);

    // A realignment discards the partial bit, so it also swallows the wrap.
    assign bit_tick = wrap_bit & ~sync_act;
    assign os_tick  = wrap_os;
    assign div_out  = div_q;

    // An outstanding request waits for a bit boundary, or lands at once when idle.
    assign apply = (st_q == ST_PEND) && (!enable || bit_tick);

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        if (baud_we) begin
            st_d = ST_PEND;
        end else if ((st_q == ST_PEND) && !apply) begin
            st_d = ST_PEND;
        end else begin
            st_d = enable ? ST_RUN : ST_IDLE;
        end
    end

    always_comb begin
        pending  = (st_q == ST_PEND);
        rate_ack = apply;
    end

    // A write coinciding with an apply is held for the next boundary.
    always_ff @(posedge clk) begin
        if (baud_we) begin
            pend_div <= res_div;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= DIV_300;
        end else if (apply) begin
            div_q <= pend_div;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            bit_cnt <= '0;
            os_cnt  <= '0;
        end else if (sync_act) begin
            bit_cnt <= div_q >> 1;
            os_cnt  <= '0;
        end else if (wrap_bit) begin
            bit_cnt <= '0;
            os_cnt  <= '0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
            os_cnt  <= wrap_os ? '0 : os_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen at 100 MHz, plus a 1 MHz instance that
// makes the 300-baud first-tick latency reachable in a short run.
module tb_baud_rate_gen;

  localparam int CNT_W = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [3:0]       baud;
  logic             baud_we;
  logic [CNT_W-1:0] custom_div;
  logic             sync_clear;
  logic             bit_tick, os_tick, pending, rate_ack;
  logic [CNT_W-1:0] div_out;

  logic             lo_enable;
  logic [3:0]       lo_baud;
  logic             lo_baud_we;
  logic [CNT_W-1:0] lo_custom_div;
  logic             lo_sync_clear;
  logic             lo_bit_tick, lo_os_tick, lo_pending, lo_rate_ack;
  logic [CNT_W-1:0] lo_div_out;

  int checks = 0;
  int errors = 0;
  int n, os_n, ack_n, ev_n;

  always #5 clk = ~clk;

  baud_rate_gen #(.CLK_HZ(100_000_000), .OVERSAMPLE(16), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .baud       (baud),
    .baud_we    (baud_we),
    .custom_div (custom_div),
    .sync_clear (sync_clear),
    .bit_tick   (bit_tick),
    .os_tick    (os_tick),
    .div_out    (div_out),
    .pending    (pending),
    .rate_ack   (rate_ack)
  );

  baud_rate_gen #(.CLK_HZ(1_000_000), .OVERSAMPLE(16), .CNT_W(CNT_W)) dut_lo (
    .clk        (clk),
    .reset      (reset),
    .enable     (lo_enable),
    .baud       (lo_baud),
    .baud_we    (lo_baud_we),
    .custom_div (lo_custom_div),
    .sync_clear (lo_sync_clear),
    .bit_tick   (lo_bit_tick),
    .os_tick    (lo_os_tick),
    .div_out    (lo_div_out),
    .pending    (lo_pending),
    .rate_ack   (lo_rate_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the chosen tick is seen (or limit), counting os/ack pulses on the way.
  task automatic wait_for(input bit on_os, input int limit,
                          output int cnt, output int os_c, output int ack_c);
    cnt = 0; os_c = 0; ack_c = 0;
    do begin
      step();
      cnt++;
      if (os_tick === 1'b1) os_c++;
      if (rate_ack === 1'b1) ack_c++;
    end while ((((on_os ? os_tick : bit_tick)) !== 1'b1) && cnt < limit);
  endtask

  // Counts the current cycle (first cycle with enable high) as cycle 1.
  task automatic first_tick(input int limit, output int cnt);
    cnt = 1;
    while (bit_tick !== 1'b1 && cnt < limit) begin
      step();
      cnt++;
    end
  endtask

  task automatic program_idle(input logic [3:0] code, input logic [CNT_W-1:0] cdiv);
    enable     = 1'b0;
    baud       = code;
    custom_div = cdiv;
    baud_we    = 1'b1;
    step();
    baud_we    = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; baud = 4'd0; baud_we = 1'b0;
    custom_div = '0; sync_clear = 1'b0;
    lo_enable = 1'b0; lo_baud = 4'd0; lo_baud_we = 1'b0;
    lo_custom_div = '0; lo_sync_clear = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    chk("rst_div", div_out, 20'd333333);
    chk("rst_pending", pending, 1'b0);
    chk("rst_bit_tick", bit_tick, 1'b0);
    chk("rst_os_tick", os_tick, 1'b0);
    chk("rst_rate_ack", rate_ack, 1'b0);
    chk("lo_rst_div", lo_div_out, 20'd3333);

    // 300 baud from reset: 1 MHz instance ticks in its 3333rd enabled cycle.
    enable = 1'b1; lo_enable = 1'b1;
    n = 1; ev_n = 0; os_n = 0;
    while (lo_bit_tick !== 1'b1 && n < 5000) begin
      step();
      n++;
      if (bit_tick === 1'b1 || rate_ack === 1'b1 || lo_rate_ack === 1'b1) ev_n++;
      if (lo_os_tick === 1'b1) os_n++;
    end
    chk("lo_first_tick", n, 3333);
    chk("lo_os_count", os_n, 16);
    chk("no_tick_no_ack", ev_n, 0);
    chk("lo_pending", lo_pending, 1'b0);
    lo_enable = 1'b0;

    // Code 8 written while idle: acknowledged the following cycle.
    enable = 1'b0; baud = 4'd8; baud_we = 1'b1;
    step();
    baud_we = 1'b0;
    chk("idle_ack", rate_ack, 1'b1);
    chk("idle_pending", pending, 1'b1);
    chk("idle_div_before", div_out, 20'd333333);
    step();
    chk("idle_div_after", div_out, 20'd868);
    chk("idle_ack_clear", rate_ack, 1'b0);
    chk("idle_pending_clear", pending, 1'b0);

    enable = 1'b1;
    first_tick(2000, n);
    chk("first_tick_868", n, 868);
    wait_for(1'b0, 2000, n, os_n, ack_n);
    chk("period_868", n, 868);
    chk("os_per_bit", os_n, 16);
    chk("no_ack_running", ack_n, 0);
    wait_for(1'b1, 200, n, os_n, ack_n);
    chk("os_after_bit", n, 54);

    // Mid-bit request for code 9 lands at the next boundary (T2+868).
    repeat (46) step();
    baud = 4'd9; baud_we = 1'b1;
    step();
    baud_we = 1'b0;
    chk("mid_pending", pending, 1'b1);
    chk("mid_div_held", div_out, 20'd868);
    wait_for(1'b0, 2000, n, os_n, ack_n);
    chk("mid_wait", n, 767);
    chk("mid_ack_count", ack_n, 1);
    chk("mid_ack_with_tick", rate_ack, 1'b1);
    wait_for(1'b0, 2000, n, os_n, ack_n);
    chk("period_434", n, 434);
    chk("div_434", div_out, 20'd434);
    chk("pending_done", pending, 1'b0);

    // sync_clear at N: os_tick at N+54, bit_tick at N+434.
    program_idle(4'd8, '0);
    enable = 1'b1;
    first_tick(2000, n);
    chk("resync_first_tick", n, 868);
    repeat (200) step();
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
    wait_for(1'b1, 2000, n, os_n, ack_n);
    chk("sync_os", n, 53);
    wait_for(1'b0, 2000, n, os_n, ack_n);
    chk("sync_bit", n, 380);

    // Two writes before one boundary: the later one wins, one ack.
    repeat (10) step();
    baud = 4'd9; baud_we = 1'b1;
    step();
    baud_we = 1'b0;
    repeat (10) step();
    baud = 4'd10; baud_we = 1'b1;
    step();
    baud_we = 1'b0;
    wait_for(1'b0, 2000, n, os_n, ack_n);
    chk("overwrite_wait", n, 846);
    chk("overwrite_acks", ack_n, 1);
    step();
    chk("overwrite_div", div_out, 20'd217);

    // sync_clear while idle has no effect on the restart.
    enable = 1'b0; sync_clear = 1'b1;
    step();
    sync_clear = 1'b0; enable = 1'b1;
    first_tick(2000, n);
    chk("idle_sync_ignored", n, 217);

    program_idle(4'd15, 20'd10);
`ifdef BAUD_CUSTOM_EN
    chk("custom_clamp", div_out, 20'd32);
`else
    chk("custom_off_10", div_out, 20'd333333);
`endif
    program_idle(4'd15, 20'd1000);
`ifdef BAUD_CUSTOM_EN
    chk("custom_1000", div_out, 20'd1000);
`else
    chk("custom_off_1000", div_out, 20'd333333);
`endif

    // Reset while a request is outstanding drops it.
    enable = 1'b1; baud = 4'd8; baud_we = 1'b1;
    step();
    baud_we = 1'b0;
    chk("pre_reset_pending", pending, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post_reset_pending", pending, 1'b0);
    chk("post_reset_div", div_out, 20'd333333);
    chk("post_reset_ack", rate_ack, 1'b0);
    wait_for(1'b0, 300, n, os_n, ack_n);
    chk("post_reset_no_tick", n, 300);
    chk("post_reset_no_ack", ack_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
